// File: rtl/full_adder_checker_if.sv
// Operand/result bus between the BIST checker and the adder under test.
interface full_adder_checker_if #(
    parameter int unsigned WIDTH = 1
);
    logic [WIDTH-1:0] a_out;
    logic [WIDTH-1:0] b_out;
    logic             ci_out;
    logic [WIDTH-1:0] sum_in;
    logic             carry_in;

    // Checker side: drives operands, samples results.
    modport master (
        output a_out,
        output b_out,
        output ci_out,
        input  sum_in,
        input  carry_in
    );

    // Adder side: consumes operands, returns results.
    modport slave (
        input  a_out,
        input  b_out,
        input  ci_out,
        output sum_in,
        output carry_in
    );
endinterface

// File: rtl/full_adder_checker.sv
// Exhaustive BIST sweep for an adder: walks every {a, b, ci}, holds each vector
// for a settle window, then compares {carry, sum} against a+b+ci.
module full_adder_checker #(
    parameter int unsigned WIDTH         = 1,
    parameter int unsigned SETTLE_CYCLES = 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    full_adder_checker_if.master   dut_if,
    output logic                   busy,
    output logic                   done,
    output logic                   pass,
    output logic [2*WIDTH+1:0]     err_count,
    output logic [2*WIDTH:0]       first_fail_vec,
    output logic                   first_fail_valid
);
    localparam int unsigned VecW = 2 * WIDTH + 1;
    localparam int unsigned ErrW = 2 * WIDTH + 2;
    localparam int unsigned CntW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [VecW-1:0] LastVec = {VecW{1'b1}};
    localparam logic [CntW-1:0] LastCnt = CntW'(SETTLE_CYCLES - 1);

    typedef enum logic [1:0] {StIdle, StSettle, StCheck, StDone} state_e;

    state_e            state_q, state_d;
    logic [VecW-1:0]   v_q, v_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic [ErrW-1:0]   err_q, err_d;
    logic [VecW-1:0]   ffv_q, ffv_d;
    logic              valid_q, valid_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              pass_q, pass_d;

    logic [WIDTH-1:0]  vec_a, vec_b;
    logic              vec_ci;
    logic [WIDTH:0]    expected;
    logic              mismatch;

    // v_q wraps to 0 on entry to DONE, so operands read 0 outside a sweep.
    assign vec_a  = v_q[VecW-1 -: WIDTH];
    assign vec_b  = v_q[WIDTH:1];
    assign vec_ci = v_q[0];

    assign dut_if.a_out  = vec_a;
    assign dut_if.b_out  = vec_b;
    assign dut_if.ci_out = vec_ci;

    // Reference result and comparison against the DUT response.
    always_comb begin
        expected = {1'b0, vec_a} + {1'b0, vec_b} + {{WIDTH{1'b0}}, vec_ci};
        mismatch = ({dut_if.carry_in, dut_if.sum_in} !== expected);
    end

    // Next-state and next-output decode for the sweep FSM.
    always_comb begin
        state_d = state_q;
        v_d     = v_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        ffv_d   = ffv_q;
        valid_d = valid_q;
        busy_d  = busy_q;
        done_d  = done_q;
        pass_d  = pass_q;
        unique case (state_q)
            StIdle, StDone: begin
                if (start) begin
                    state_d = StSettle;
                    v_d     = '0;
                    cnt_d   = '0;
                    err_d   = '0;
                    ffv_d   = '0;
                    valid_d = 1'b0;
                    busy_d  = 1'b1;
                    done_d  = 1'b0;
                    pass_d  = 1'b0;
                end
            end
            StSettle: begin
                if (cnt_q == LastCnt) begin
                    cnt_d   = '0;
                    state_d = StCheck;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StCheck: begin
                if (mismatch) begin
                    err_d = err_q + 1'b1;
                    if (!valid_q) begin
                        ffv_d   = v_q;
                        valid_d = 1'b1;
                    end
                end
                v_d = v_q + 1'b1;
                if (v_q == LastVec) begin
                    state_d = StDone;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    pass_d  = (err_d == '0);
                end else begin
                    state_d = StSettle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // FSM state and registered outputs; reset clears everything immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            v_q     <= '0;
            cnt_q   <= '0;
            err_q   <= '0;
            ffv_q   <= '0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            v_q     <= v_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
            ffv_q   <= ffv_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            pass_q  <= pass_d;
        end
    end

    assign busy             = busy_q;
    assign done             = done_q;
    assign pass             = pass_q;
    assign err_count        = err_q;
    assign first_fail_vec   = ffv_q;
    assign first_fail_valid = valid_q;
endmodule

// File: doc/full_adder_checker.md
Name: full_adder_checker

Overview:
- Hardware response checker for the team's adder blocks; a self-checking BIST engine.
- Generates every {a, b, ci} input combination and drives it to a DUT adder.
- Samples the DUT's sum/carry after a settle window and compares them with the expected a+b+ci.
- Reports an error count, the first failing vector, and pass/done status.
- Sits beside the full adder in FPGA bring-up, replacing the simulation-only stimulus loop.

Parameters:
WIDTH, 1, operand width of a/b/sum; vector count NV = 2^(2*WIDTH+1).
SETTLE_CYCLES, 1, cycles each vector is held before the check cycle; legal range >= 1.

Ports:
clk  input  1  rising-edge clock.
rst_n  input  1  asynchronous active-low reset.
start  input  1  single-cycle request to run a full sweep.
a_out  output  WIDTH  operand a driven to DUT.
b_out  output  WIDTH  operand b driven to DUT.
ci_out  output  1  carry-in driven to DUT.
sum_in  input  WIDTH  DUT sum.
carry_in  input  1  DUT carry-out.
busy  output  1  sweep in progress.
done  output  1  sweep complete; held until next accepted start.
pass  output  1  done and zero errors.
err_count  output  2*WIDTH+2  number of mismatching vectors.
first_fail_vec  output  2*WIDTH+1  index of first mismatching vector.
first_fail_valid  output  1  first_fail_vec holds a captured value.

Behaviour:
- Reset (rst_n low, asynchronous): state IDLE; all outputs 0, including a_out/b_out/ci_out.
- Vector index v runs 0..NV-1 and is decoded as {a, b, ci}: a occupies the top WIDTH bits and ci is bit 0, so a is the outermost loop. The index is registered and drives a_out/b_out/ci_out directly.
- FSM states: IDLE, SETTLE, CHECK, DONE.
- IDLE:
  - busy=0 and the operand outputs are 0.
  - start=1 at a clock edge: clear err_count, first_fail_vec and first_fail_valid; v=0; settle counter=0; go to SETTLE.
- SETTLE:
  - busy=1 and vector v is driven.
  - Stays for exactly SETTLE_CYCLES cycles, then goes to CHECK.
- CHECK:
  - busy=1 and vector v is still driven.
  - At the edge leaving CHECK, {carry_in, sum_in} is compared with the (WIDTH+1)-bit result of a+b+ci.
  - On mismatch: err_count increments. If first_fail_valid=0, capture first_fail_vec=v and set first_fail_valid=1.
  - If v==NV-1, go to DONE. Otherwise v=v+1 and return to SETTLE.
- DONE:
  - busy=0, done=1, and pass = (err_count==0).
  - Operand outputs return to 0; result registers are held.
  - start=1 behaves as in IDLE: results clear, done drops, and a new sweep begins.
- Timing:
  - Each vector occupies SETTLE_CYCLES+1 cycles.
  - done rises NV*(SETTLE_CYCLES+1) cycles after the edge that accepted start. For WIDTH=1, SETTLE_CYCLES=1 this is 16 cycles.
- start while busy: ignored; the sweep is not restarted or extended.
- err_count never overflows, since NV < 2^(2*WIDTH+2). Wrap-around of v occurs only at the transition into DONE.
- rst_n asserted mid-sweep: immediate return to IDLE with all outputs 0. There is no resume; a new start is required after reset releases.
- DUT inputs are sampled only in CHECK; values during SETTLE are don't-care.

Test Plan:
1. WIDTH=1, SETTLE_CYCLES=1, correct full adder attached; one start pulse -> vectors 000,001,...,111 each held 2 cycles, busy high for 16 cycles, then done=1, pass=1, err_count=0, first_fail_valid=0.
2. Faulty DUT with carry stuck at 0 -> err_count=4 (vectors 3,5,6,7), first_fail_vec=3, first_fail_valid=1, pass=0.
3. Faulty DUT with sum inverted -> err_count=8, first_fail_vec=0, pass=0, done=1 at cycle 16.
4. start re-pulsed at cycle 5 of a sweep -> ignored, done still at cycle 16. start pulsed in DONE -> results cleared, done=0, second sweep completes identically.
5. rst_n driven low at cycle 7 -> same-cycle busy=0, a_out/b_out/ci_out=0, err_count=0. After release, stays IDLE with no activity until start.
6. WIDTH=2, SETTLE_CYCLES=3, correct 2-bit adder -> 32 vectors, done after 128 cycles, pass=1. A DUT with sum bit 1 stuck at 1 gives first_fail_vec=0 and err_count=16.
